// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI bus-interface sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ppi_pkg;

    // Bus cycle sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Control-word field positions (always within bits [7:0] of the data bus)
    localparam int CTRL_MODE_BIT = 7;
    localparam int BSR_BIT_LSB   = 1;
    localparam int BSR_BIT_MSB   = 3;
    localparam int BSR_VAL_BIT   = 0;

    // Mode 0, all ports configured as inputs
    localparam logic [7:0] CTRL_RST_DEFAULT = 8'h9B;

endpackage

// File: rtl/ppi_addr_decode.sv
// Address decoder: register address -> one-hot port select, control select, unmapped flag.
// Latency: combinational, zero cycles.
// Backpressure: none.
module ppi_addr_decode #(
    parameter int ADDR_W  = 2,
    parameter int N_PORTS = 3
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [N_PORTS-1:0] port_sel,
    output logic               ctrl_sel,
    output logic               unmapped
);

    // Ports occupy 0..N_PORTS-1, control register is the all-ones address, the rest is a hole
    always_comb begin
        port_sel = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (addr == ADDR_W'(i)) begin
                port_sel[i] = 1'b1;
            end
        end
        ctrl_sel = (addr == {ADDR_W{1'b1}});
        unmapped = !ctrl_sel && (port_sel == '0);
    end

endmodule

// File: rtl/ppi_bus_ctrl_seq.sv
// PPI bus-interface sequencer: read/write cycle FSM, port selects, control word, commit strobes.
// Latency: strobes appear one cycle after the sampled WR_n rising (or RD_n falling) edge.
// Backpressure: none; strobes are single-cycle pulses the port/group blocks must accept.
module ppi_bus_ctrl_seq
    import ppi_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter int         ADDR_W   = 2,
    parameter int         N_PORTS  = 3,
    parameter logic [7:0] CTRL_RST = CTRL_RST_DEFAULT
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               CS_n,
    input  logic               RD_n,
    input  logic               WR_n,
    input  logic [ADDR_W-1:0]  A,
    input  logic [DATA_W-1:0]  D_in,
    output logic               bus_dir,
    output logic [N_PORTS-1:0] port_sel,
    output logic               ctrl_sel,
    output logic               port_rd_stb,
    output logic               port_wr_stb,
    output logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  ctrl_word,
    output logic               mode_stb,
    output logic               bsr_stb,
    output logic [2:0]         bsr_bit,
    output logic               bsr_val,
    output logic               err_stb
);

    localparam logic [DATA_W-1:0] CTRL_RST_W = DATA_W'(CTRL_RST);

    state_t              state;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                active;

    logic [N_PORTS-1:0]  in_port_sel;
    logic                in_ctrl_sel;
    logic                in_unmapped;
    logic [N_PORTS-1:0]  lat_port_sel;
    logic                lat_ctrl_sel;
    logic                lat_unmapped;

    assign active = !CS_n;

    // Live address: used on read entry and to drive selects while WR_n is low
    ppi_addr_decode #(
        .ADDR_W  (ADDR_W),
        .N_PORTS (N_PORTS)
    ) u_dec_in (
        .addr     (A),
        .port_sel (in_port_sel),
        .ctrl_sel (in_ctrl_sel),
        .unmapped (in_unmapped)
    );

    // Latched address: the last value sampled with WR_n low decides the commit target
    ppi_addr_decode #(
        .ADDR_W  (ADDR_W),
        .N_PORTS (N_PORTS)
    ) u_dec_lat (
        .addr     (lat_addr),
        .port_sel (lat_port_sel),
        .ctrl_sel (lat_ctrl_sel),
        .unmapped (lat_unmapped)
    );

    // Cycle FSM with registered selects, strobes and control word; strobes default low every cycle
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_data    <= '0;
            bus_dir     <= 1'b0;
            port_sel    <= '0;
            ctrl_sel    <= 1'b0;
            port_rd_stb <= 1'b0;
            port_wr_stb <= 1'b0;
            wr_data     <= '0;
            ctrl_word   <= CTRL_RST_W;
            mode_stb    <= 1'b0;
            bsr_stb     <= 1'b0;
            bsr_bit     <= '0;
            bsr_val     <= 1'b0;
            err_stb     <= 1'b0;
        end else begin
            port_rd_stb <= 1'b0;
            port_wr_stb <= 1'b0;
            mode_stb    <= 1'b0;
            bsr_stb     <= 1'b0;
            err_stb     <= 1'b0;

            case (state)
                IDLE: begin
                    bus_dir  <= 1'b0;
                    port_sel <= '0;
                    ctrl_sel <= 1'b0;
                    if (active && !RD_n && !WR_n) begin
                        // Contending strobes: flag and wait for the bus to settle
                        err_stb <= 1'b1;
                    end else if (active && !RD_n) begin
                        state    <= READ;
                        lat_addr <= A;
                        if (in_unmapped) begin
                            // Hole in the map: report once, never drive the bus
                            err_stb <= 1'b1;
                        end else begin
                            bus_dir     <= 1'b1;
                            port_sel    <= in_port_sel;
                            ctrl_sel    <= in_ctrl_sel;
                            port_rd_stb <= |in_port_sel;
                        end
                    end else if (active && !WR_n) begin
                        state    <= WRITE;
                        lat_addr <= A;
                        lat_data <= D_in;
                        port_sel <= in_port_sel;
                        ctrl_sel <= in_ctrl_sel;
                    end
                end

                READ: begin
                    if (!active || RD_n) begin
                        state    <= IDLE;
                        bus_dir  <= 1'b0;
                        port_sel <= '0;
                        ctrl_sel <= 1'b0;
                    end else if (!WR_n) begin
                        state    <= IDLE;
                        bus_dir  <= 1'b0;
                        port_sel <= '0;
                        ctrl_sel <= 1'b0;
                        err_stb  <= 1'b1;
                    end
                end

                WRITE: begin
                    if (!active) begin
                        // Chip deselected before WR_n rose: drop the write silently
                        state    <= IDLE;
                        port_sel <= '0;
                        ctrl_sel <= 1'b0;
                    end else if (!WR_n && !RD_n) begin
                        state    <= IDLE;
                        port_sel <= '0;
                        ctrl_sel <= 1'b0;
                        err_stb  <= 1'b1;
                    end else if (!WR_n) begin
                        // Still low: keep tracking the bus, last sample wins
                        lat_addr <= A;
                        lat_data <= D_in;
                        port_sel <= in_port_sel;
                        ctrl_sel <= in_ctrl_sel;
                    end else begin
                        // WR_n rose with chip still selected: commit the latched write
                        state    <= IDLE;
                        port_sel <= lat_port_sel;
                        ctrl_sel <= lat_ctrl_sel;
                        if (lat_unmapped) begin
                            err_stb <= 1'b1;
                        end else if (|lat_port_sel) begin
                            port_wr_stb <= 1'b1;
                            wr_data     <= lat_data;
                        end else if (lat_data[CTRL_MODE_BIT]) begin
                            ctrl_word <= lat_data;
                            mode_stb  <= 1'b1;
                        end else begin
                            bsr_stb <= 1'b1;
                            bsr_bit <= lat_data[BSR_BIT_MSB:BSR_BIT_LSB];
                            bsr_val <= lat_data[BSR_VAL_BIT];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_bus_ctrl_seq.sv
module tb_ppi_bus_ctrl_seq;

    typedef struct packed {
        logic [4:0]  stb;   // {rd, wr, mode, bsr, err}
        logic [3:0]  sel;   // {ctrl_sel, port_sel padded to 3 bits}
        logic [15:0] pay;
    } ev_t;

    localparam logic [4:0] S_RD   = 5'b10000;
    localparam logic [4:0] S_WR   = 5'b01000;
    localparam logic [4:0] S_MODE = 5'b00100;
    localparam logic [4:0] S_BSR  = 5'b00010;
    localparam logic [4:0] S_ERR  = 5'b00001;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [1:0] a = '0;
    logic [7:0] d = '0;
    logic       use2 = 1'b0;
    logic       cs1_n, cs2_n;

    assign cs1_n = use2 ? 1'b1 : cs_n;
    assign cs2_n = use2 ? cs_n : 1'b1;

    // DUT 1: default parameters
    logic       bus_dir1, ctrl_sel1, rd_stb1, wr_stb1, mode_stb1, bsr_stb1, bsr_val1, err_stb1;
    logic [2:0] port_sel1, bsr_bit1;
    logic [7:0] wr_data1, ctrl_word1;

    // DUT 2: two ports, address 2 is a hole
    logic       bus_dir2, ctrl_sel2, rd_stb2, wr_stb2, mode_stb2, bsr_stb2, bsr_val2, err_stb2;
    logic [1:0] port_sel2;
    logic [2:0] bsr_bit2;
    logic [7:0] wr_data2, ctrl_word2;

    ppi_bus_ctrl_seq #(.DATA_W(8), .ADDR_W(2), .N_PORTS(3), .CTRL_RST(8'h9B)) dut1 (
        .clk(clk), .Reset(Reset), .CS_n(cs1_n), .RD_n(rd_n), .WR_n(wr_n), .A(a), .D_in(d),
        .bus_dir(bus_dir1), .port_sel(port_sel1), .ctrl_sel(ctrl_sel1),
        .port_rd_stb(rd_stb1), .port_wr_stb(wr_stb1), .wr_data(wr_data1), .ctrl_word(ctrl_word1),
        .mode_stb(mode_stb1), .bsr_stb(bsr_stb1), .bsr_bit(bsr_bit1), .bsr_val(bsr_val1),
        .err_stb(err_stb1)
    );

    ppi_bus_ctrl_seq #(.DATA_W(8), .ADDR_W(2), .N_PORTS(2), .CTRL_RST(8'h9B)) dut2 (
        .clk(clk), .Reset(Reset), .CS_n(cs2_n), .RD_n(rd_n), .WR_n(wr_n), .A(a), .D_in(d),
        .bus_dir(bus_dir2), .port_sel(port_sel2), .ctrl_sel(ctrl_sel2),
        .port_rd_stb(rd_stb2), .port_wr_stb(wr_stb2), .wr_data(wr_data2), .ctrl_word(ctrl_word2),
        .mode_stb(mode_stb2), .bsr_stb(bsr_stb2), .bsr_bit(bsr_bit2), .bsr_val(bsr_val2),
        .err_stb(err_stb2)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    ev_t  q1[$];
    ev_t  q2[$];

    function automatic ev_t snap(input logic [4:0] stb, input logic [3:0] sel,
                                 input logic [7:0] wd, input logic [7:0] cw,
                                 input logic [2:0] bb, input logic bv);
        ev_t e;
        e.stb = stb;
        e.sel = sel;
        if (stb == S_WR)       e.pay = {8'h00, wd};
        else if (stb == S_BSR) e.pay = {cw, 4'b0000, bb, bv};
        else                   e.pay = {cw, 8'h00};
        return e;
    endfunction

    // Scoreboard monitor for DUT 1
    always @(negedge clk) begin
        ev_t o, e;
        o = snap({rd_stb1, wr_stb1, mode_stb1, bsr_stb1, err_stb1}, {ctrl_sel1, port_sel1},
                 wr_data1, ctrl_word1, bsr_bit1, bsr_val1);
        if (o.stb != 5'b0) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_unexpected_strobe: got %h required none", o);
            end else begin
                e = q1.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL dut1_event: got %h required %h", o, e);
                end
            end
        end
    end

    // Scoreboard monitor for DUT 2
    always @(negedge clk) begin
        ev_t o, e;
        o = snap({rd_stb2, wr_stb2, mode_stb2, bsr_stb2, err_stb2}, {ctrl_sel2, 1'b0, port_sel2},
                 wr_data2, ctrl_word2, bsr_bit2, bsr_val2);
        if (o.stb != 5'b0) begin
            n_chk++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL dut2_unexpected_strobe: got %h required none", o);
            end else begin
                e = q2.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL dut2_event: got %h required %h", o, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Apply one bus state and let one rising edge sample it
    task automatic drive(input logic c, input logic r, input logic w,
                         input logic [1:0] aa, input logic [7:0] dd);
        cs_n = c; rd_n = r; wr_n = w; a = aa; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    endtask

    initial begin
        ev_t e;
        idle(2);
        chk("reset_ctrl_word", {24'h0, ctrl_word1}, 32'h9B);
        chk("reset_outputs", {bus_dir1, port_sel1, ctrl_sel1, rd_stb1, wr_stb1, mode_stb1,
                              bsr_stb1, err_stb1, bsr_bit1, bsr_val1, wr_data1}, 32'h0);
        Reset = 1'b0;
        idle(1);

        // Port write to A=1, WR_n low three samples
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h5A);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h5A);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h5A);
        chk("write_sel_during_cycle", {29'h0, port_sel1}, 32'h2);
        e = '{stb: S_WR, sel: 4'b0010, pay: 16'h005A}; q1.push_back(e);
        drive(1'b0, 1'b1, 1'b1, 2'd1, 8'h5A);
        chk("wr_stb_latency", {31'h0, wr_stb1}, 32'h1);
        idle(1);
        chk("wr_stb_one_cycle", {31'h0, wr_stb1}, 32'h0);

        // Mode set, then bit set/reset leaves control word alone
        drive(1'b0, 1'b1, 1'b0, 2'd3, 8'h80);
        e = '{stb: S_MODE, sel: 4'b1000, pay: 16'h8000}; q1.push_back(e);
        drive(1'b0, 1'b1, 1'b1, 2'd3, 8'h80);
        idle(1);
        chk("mode_ctrl_word", {24'h0, ctrl_word1}, 32'h80);
        drive(1'b0, 1'b1, 1'b0, 2'd3, 8'h07);
        e = '{stb: S_BSR, sel: 4'b1000, pay: 16'h8007}; q1.push_back(e);
        drive(1'b0, 1'b1, 1'b1, 2'd3, 8'h07);
        idle(1);
        chk("bsr_keeps_ctrl_word", {24'h0, ctrl_word1}, 32'h80);

        // Reset held two cycles in the middle of a write
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h11);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h11);
        Reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h11);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h11);
        chk("midwrite_reset_ctrl_word", {24'h0, ctrl_word1}, 32'h9B);
        chk("midwrite_reset_outputs", {26'h0, bus_dir1, port_sel1, ctrl_sel1, wr_stb1}, 32'h0);
        Reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 2'd1, 8'h11);
        chk("no_commit_after_reset", {31'h0, wr_stb1}, 32'h0);
        idle(2);

        // Read of port 2 held four samples
        e = '{stb: S_RD, sel: 4'b0100, pay: 16'h9B00}; q1.push_back(e);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd2, 8'h00);
            chk("read_bus_dir", {31'h0, bus_dir1}, 32'h1);
            chk("read_port_sel", {29'h0, port_sel1}, 32'h4);
        end
        drive(1'b0, 1'b1, 1'b1, 2'd2, 8'h00);
        chk("read_end_bus_dir", {31'h0, bus_dir1}, 32'h0);
        chk("read_end_port_sel", {29'h0, port_sel1}, 32'h0);
        idle(1);

        // Deselect before WR_n rises: silent abort
        drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h33);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h33);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h33);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h33);
        chk("abort_no_strobe", {30'h0, wr_stb1, err_stb1}, 32'h0);
        idle(1);

        // RD_n and WR_n both low from IDLE, then during a write
        e = '{stb: S_ERR, sel: 4'b0000, pay: 16'h9B00}; q1.push_back(e);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h44);
        chk("contend_idle_err", {31'h0, err_stb1}, 32'h1);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h44);
        e = '{stb: S_ERR, sel: 4'b0000, pay: 16'h9B00}; q1.push_back(e);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h44);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h44);
        chk("contend_write_no_commit", {31'h0, wr_stb1}, 32'h0);
        idle(2);

        // Two-port instance: hole at A=2, then back-to-back writes
        use2 = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 8'hAA);
        chk("hole_sel_during", {30'h0, port_sel2}, 32'h0);
        e = '{stb: S_ERR, sel: 4'b0000, pay: 16'h9B00}; q2.push_back(e);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 8'hAA);
        chk("hole_sel_commit", {30'h0, port_sel2}, 32'h0);
        chk("hole_err", {31'h0, err_stb2}, 32'h1);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 8'hC1);
        e = '{stb: S_WR, sel: 4'b0001, pay: 16'h00C1}; q2.push_back(e);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'hC1);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'hC2);
        e = '{stb: S_WR, sel: 4'b0010, pay: 16'h00C2}; q2.push_back(e);
        drive(1'b0, 1'b1, 1'b1, 2'd1, 8'hC2);
        idle(3);
        use2 = 1'b0;

        chk("dut1_events_drained", q1.size(), 32'd0);
        chk("dut2_events_drained", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
